// File: rtl/rast_pkg.sv
// rtl/rast_pkg.sv - shared rasterizer constants: coordinate defaults, octant codes, capture-word layout
package rast_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int TAG_W_DEF   = 4;

    localparam logic [1:0] OCT_SHALLOW_POS = 2'b01;
    localparam logic [1:0] OCT_STEEP_POS   = 2'b00;
    localparam logic [1:0] OCT_SHALLOW_NEG = 2'b10;
    localparam logic [1:0] OCT_STEEP_NEG   = 2'b11;

    // Capture word is {x0, y0, x1, y1, tag} with x0 in the MSBs.
    localparam int FLD_TAG = 0;
    localparam int FLD_Y1  = 1;
    localparam int FLD_X1  = 2;
    localparam int FLD_Y0  = 3;
    localparam int FLD_X0  = 4;

    function automatic int cap_lsb(input int fld, input int coord_w, input int tag_w);
        return (fld == FLD_TAG) ? 0 : tag_w + (fld - 1) * coord_w;
    endfunction

    localparam int TAG_LSB_DEF = cap_lsb(FLD_TAG, COORD_W_DEF, TAG_W_DEF);
    localparam int Y1_LSB_DEF  = cap_lsb(FLD_Y1,  COORD_W_DEF, TAG_W_DEF);
    localparam int X1_LSB_DEF  = cap_lsb(FLD_X1,  COORD_W_DEF, TAG_W_DEF);
    localparam int Y0_LSB_DEF  = cap_lsb(FLD_Y0,  COORD_W_DEF, TAG_W_DEF);
    localparam int X0_LSB_DEF  = cap_lsb(FLD_X0,  COORD_W_DEF, TAG_W_DEF);

endpackage

// File: rtl/line_classify.sv
// rtl/line_classify.sv - combinational line classification; endpoint swap under LINE_SETUP_SWAP_EN
module line_classify
    import rast_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W:0]   dx_in,
    input  logic [COORD_W:0]   dy_in,
    output logic [COORD_W:0]   dx,
    output logic [COORD_W:0]   dy,
    output logic [COORD_W-1:0] abs_dx,
    output logic [COORD_W-1:0] abs_dy,
    output logic               steep,
    output logic [1:0]         steep_octant,
    output logic [2:0]         octant,
    output logic               x_step,
    output logic               y_step,
    output logic [COORD_W-1:0] major_len,
    output logic [COORD_W+1:0] err_init,
    output logic               degenerate,
    output logic [COORD_W-1:0] start_x,
    output logic [COORD_W-1:0] start_y,
    output logic [COORD_W-1:0] end_x,
    output logic [COORD_W-1:0] end_y,
    output logic               swapped
);

    logic               dx_neg;
    logic               dy_neg;
    logic               polarity;
    logic [COORD_W-1:0] minor_len;

    assign dx_neg = dx_in[COORD_W];
    assign dy_neg = dy_in[COORD_W];

    // Low COORD_W bits of the negation are the magnitude, even for -(2^COORD_W-1).
    assign abs_dx = dx_neg ? COORD_W'(-dx_in) : dx_in[COORD_W-1:0];
    assign abs_dy = dy_neg ? COORD_W'(-dy_in) : dy_in[COORD_W-1:0];

    assign steep      = abs_dy > abs_dx;
    assign polarity   = dx_neg ^ dy_neg;
    assign major_len  = steep ? abs_dy : abs_dx;
    assign minor_len  = steep ? abs_dx : abs_dy;
    assign err_init   = {1'b0, minor_len, 1'b0} - {2'b00, major_len};
    assign degenerate = (dx_in == '0) && (dy_in == '0);

    always_comb begin
        steep_octant = OCT_SHALLOW_POS;
        case ({polarity, steep})
            2'b00:   steep_octant = OCT_SHALLOW_POS;
            2'b01:   steep_octant = OCT_STEEP_POS;
            2'b10:   steep_octant = OCT_SHALLOW_NEG;
            default: steep_octant = OCT_STEEP_NEG;
        endcase
    end

`ifdef LINE_SETUP_SWAP_EN
    // Walk from the other end so the major axis always increments.
    assign swapped = steep ? dy_neg : dx_neg;
`else
    assign swapped = 1'b0;
`endif

    assign dx      = swapped ? -dx_in : dx_in;
    assign dy      = swapped ? -dy_in : dy_in;
    assign x_step  = dx[COORD_W];
    assign y_step  = dy[COORD_W];
    assign octant  = {x_step, y_step, steep};
    assign start_x = swapped ? x1 : x0;
    assign start_y = swapped ? y1 : y0;
    assign end_x   = swapped ? x0 : x1;
    assign end_y   = swapped ? y0 : y1;

endmodule

// File: rtl/line_setup_pipe.sv
// rtl/line_setup_pipe.sv - two-stage line setup pipeline; LINE_SETUP_SWAP_EN enables endpoint swap
module line_setup_pipe
    import rast_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4*COORD_W+TAG_W-1:0] line_cap_reg,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COORD_W:0]           dx,
    output logic [COORD_W:0]           dy,
    output logic [COORD_W-1:0]         abs_dx,
    output logic [COORD_W-1:0]         abs_dy,
    output logic                       steep,
    output logic [1:0]                 steep_octant,
    output logic [2:0]                 octant,
    output logic                       x_step,
    output logic                       y_step,
    output logic [COORD_W-1:0]         major_len,
    output logic [COORD_W+1:0]         err_init,
    output logic                       degenerate,
    output logic [TAG_W-1:0]           tag_out,
    output logic [COORD_W-1:0]         start_x,
    output logic [COORD_W-1:0]         start_y,
    output logic [COORD_W-1:0]         end_x,
    output logic [COORD_W-1:0]         end_y,
    output logic                       swapped
);

    localparam int TAG_LSB = cap_lsb(FLD_TAG, COORD_W, TAG_W);
    localparam int Y1_LSB  = cap_lsb(FLD_Y1,  COORD_W, TAG_W);
    localparam int X1_LSB  = cap_lsb(FLD_X1,  COORD_W, TAG_W);
    localparam int Y0_LSB  = cap_lsb(FLD_Y0,  COORD_W, TAG_W);
    localparam int X0_LSB  = cap_lsb(FLD_X0,  COORD_W, TAG_W);

    logic [COORD_W-1:0] cap_x0, cap_y0, cap_x1, cap_y1;
    logic [TAG_W-1:0]   cap_tag;

    logic               s1_valid;
    logic [COORD_W-1:0] s1_x0, s1_y0, s1_x1, s1_y1;
    logic [TAG_W-1:0]   s1_tag;
    logic [COORD_W:0]   s1_dx, s1_dy;
    logic               s1_load, s2_load;

    logic [COORD_W:0]   c_dx, c_dy;
    logic [COORD_W-1:0] c_abs_dx, c_abs_dy, c_major_len;
    logic [COORD_W-1:0] c_start_x, c_start_y, c_end_x, c_end_y;
    logic [COORD_W+1:0] c_err_init;
    logic [1:0]         c_steep_octant;
    logic [2:0]         c_octant;
    logic               c_steep, c_x_step, c_y_step, c_degenerate, c_swapped;

    assign cap_x0  = line_cap_reg[X0_LSB +: COORD_W];
    assign cap_y0  = line_cap_reg[Y0_LSB +: COORD_W];
    assign cap_x1  = line_cap_reg[X1_LSB +: COORD_W];
    assign cap_y1  = line_cap_reg[Y1_LSB +: COORD_W];
    assign cap_tag = line_cap_reg[TAG_LSB +: TAG_W];

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x0    <= '0;
            s1_y0    <= '0;
            s1_x1    <= '0;
            s1_y1    <= '0;
            s1_tag   <= '0;
            s1_dx    <= '0;
            s1_dy    <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_x0  <= cap_x0;
                s1_y0  <= cap_y0;
                s1_x1  <= cap_x1;
                s1_y1  <= cap_y1;
                s1_tag <= cap_tag;
                s1_dx  <= {1'b0, cap_x1} - {1'b0, cap_x0};
                s1_dy  <= {1'b0, cap_y1} - {1'b0, cap_y0};
            end
        end
    end

    line_classify #(.COORD_W(COORD_W)) u_classify (
        .x0           (s1_x0),
        .y0           (s1_y0),
        .x1           (s1_x1),
        .y1           (s1_y1),
        .dx_in        (s1_dx),
        .dy_in        (s1_dy),
        .dx           (c_dx),
        .dy           (c_dy),
        .abs_dx       (c_abs_dx),
        .abs_dy       (c_abs_dy),
        .steep        (c_steep),
        .steep_octant (c_steep_octant),
        .octant       (c_octant),
        .x_step       (c_x_step),
        .y_step       (c_y_step),
        .major_len    (c_major_len),
        .err_init     (c_err_init),
        .degenerate   (c_degenerate),
        .start_x      (c_start_x),
        .start_y      (c_start_y),
        .end_x        (c_end_x),
        .end_y        (c_end_y),
        .swapped      (c_swapped)
    );

    // Result registers only change on a real load so a stalled result holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            dx           <= '0;
            dy           <= '0;
            abs_dx       <= '0;
            abs_dy       <= '0;
            steep        <= 1'b0;
            steep_octant <= '0;
            octant       <= '0;
            x_step       <= 1'b0;
            y_step       <= 1'b0;
            major_len    <= '0;
            err_init     <= '0;
            degenerate   <= 1'b0;
            tag_out      <= '0;
            start_x      <= '0;
            start_y      <= '0;
            end_x        <= '0;
            end_y        <= '0;
            swapped      <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                dx           <= c_dx;
                dy           <= c_dy;
                abs_dx       <= c_abs_dx;
                abs_dy       <= c_abs_dy;
                steep        <= c_steep;
                steep_octant <= c_steep_octant;
                octant       <= c_octant;
                x_step       <= c_x_step;
                y_step       <= c_y_step;
                major_len    <= c_major_len;
                err_init     <= c_err_init;
                degenerate   <= c_degenerate;
                tag_out      <= s1_tag;
                start_x      <= c_start_x;
                start_y      <= c_start_y;
                end_x        <= c_end_x;
                end_y        <= c_end_y;
                swapped      <= c_swapped;
            end
        end
    end

endmodule

// File: tb/tb_line_setup_pipe.sv
// tb/tb_line_setup_pipe.sv - scoreboard bench for line_setup_pipe (honours LINE_SETUP_SWAP_EN)
module tb_line_setup_pipe;

    typedef struct {
        int dx, dy, adx, ady, steep, so, oct, xs, ys, major, err, degen, tag, sx, sy, ex, ey, sw;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [43:0]  line_cap_reg = '0;
    logic         in_ready, out_valid;
    logic [10:0]  dx, dy;
    logic [9:0]   abs_dx, abs_dy, major_len, start_x, start_y, end_x, end_y;
    logic         steep, x_step, y_step, degenerate, swapped;
    logic [1:0]   steep_octant;
    logic [2:0]   octant;
    logic [11:0]  err_init;
    logic [3:0]   tag_out;
    logic [127:0] cur, snap;

    exp_t sb[$];
    exp_t me;
    int   total = 0;
    int   bad = 0;
    int   acc_cnt = 0;
    bit   stall_prev = 0;
    bit   rnd_done = 0;

    line_setup_pipe #(.COORD_W(10), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .line_cap_reg(line_cap_reg), .out_valid(out_valid), .out_ready(out_ready),
        .dx(dx), .dy(dy), .abs_dx(abs_dx), .abs_dy(abs_dy), .steep(steep),
        .steep_octant(steep_octant), .octant(octant), .x_step(x_step), .y_step(y_step),
        .major_len(major_len), .err_init(err_init), .degenerate(degenerate),
        .tag_out(tag_out), .start_x(start_x), .start_y(start_y), .end_x(end_x),
        .end_y(end_y), .swapped(swapped)
    );

    always #5 clk = ~clk;

    assign cur = {10'b0, dx, dy, abs_dx, abs_dy, steep, steep_octant, octant, x_step, y_step,
                  major_len, err_init, degenerate, tag_out, start_x, start_y, end_x, end_y, swapped};

    function automatic void chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endfunction

    function automatic exp_t model(input int x0, input int y0, input int x1, input int y1, input int tg);
        exp_t e;
        int   so_tab[4] = '{1, 0, 2, 3};
        int   minor;
        bit   swap;
        e.dx    = x1 - x0;
        e.dy    = y1 - y0;
        e.adx   = (e.dx < 0) ? -e.dx : e.dx;
        e.ady   = (e.dy < 0) ? -e.dy : e.dy;
        e.steep = (e.ady > e.adx) ? 1 : 0;
        e.major = e.steep ? e.ady : e.adx;
        minor   = e.steep ? e.adx : e.ady;
        e.err   = 2 * minor - e.major;
        e.degen = (e.dx == 0 && e.dy == 0) ? 1 : 0;
        e.so    = so_tab[(((e.dx < 0) != (e.dy < 0)) ? 2 : 0) + e.steep];
        e.tag   = tg;
        swap    = 0;
`ifdef LINE_SETUP_SWAP_EN
        swap    = e.steep ? (e.dy < 0) : (e.dx < 0);
`endif
        if (swap) begin
            e.dx = -e.dx; e.dy = -e.dy;
            e.sx = x1; e.sy = y1; e.ex = x0; e.ey = y0; e.sw = 1;
        end else begin
            e.sx = x0; e.sy = y0; e.ex = x1; e.ey = y1; e.sw = 0;
        end
        e.xs  = (e.dx < 0) ? 1 : 0;
        e.ys  = (e.dy < 0) ? 1 : 0;
        e.oct = e.xs * 4 + e.ys * 2 + e.steep;
        return e;
    endfunction

    function automatic void check_res(input exp_t e);
        chk("dx", $signed(dx), e.dx);
        chk("dy", $signed(dy), e.dy);
        chk("abs_dx", abs_dx, e.adx);
        chk("abs_dy", abs_dy, e.ady);
        chk("steep", steep, e.steep);
        chk("steep_octant", steep_octant, e.so);
        chk("octant", octant, e.oct);
        chk("x_step", x_step, e.xs);
        chk("y_step", y_step, e.ys);
        chk("major_len", major_len, e.major);
        chk("err_init", $signed(err_init), e.err);
        chk("degenerate", degenerate, e.degen);
        chk("tag_out", tag_out, e.tag);
        chk("start_x", start_x, e.sx);
        chk("start_y", start_y, e.sy);
        chk("end_x", end_x, e.ex);
        chk("end_y", end_y, e.ey);
        chk("swapped", swapped, e.sw);
    endfunction

    // Monitor: pops the scoreboard on every output transfer and checks hold during stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                total++;
                if (cur !== snap) begin
                    bad++;
                    $display("FAIL hold_stable got=%h want=%h", cur, snap);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    me = sb.pop_front();
                    check_res(me);
                end
            end
        end
        stall_prev = !rst && out_valid && !out_ready;
        snap = cur;
    end

    task automatic align;
        @(posedge clk);
        #1;
    endtask

    function automatic int rc();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return 1023;
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send_one(input int x0, input int y0, input int x1, input int y1, input int tg);
        logic [9:0] a, b, c, d;
        logic [3:0] t;
        int         waitc = 0;
        a = 10'(x0); b = 10'(y0); c = 10'(x1); d = 10'(y1); t = 4'(tg);
        line_cap_reg = {a, b, c, d, t};
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(x0, y0, x1, y1, tg));
                acc_cnt++;
                break;
            end
            waitc++;
            if (waitc > 300) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_lat(input int x0, input int y0, input int x1, input int y1, input int tg);
        send_one(x0, y0, x1, y1, tg);
        @(negedge clk);
        chk("lat_early", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        align();
    endtask

    initial begin
        int cnt;
        int base;
        fork
            begin
                #400000;
                $display("FAIL watchdog got=timeout want=finish");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dx", dx, 0);
        chk("rst_major", major_len, 0);
        chk("rst_tag", tag_out, 0);
        align();

        send_lat(0, 0, 10, 3, 5);
        chk("t1_dx", $signed(dx), 10);
        chk("t1_steep", steep, 0);
        chk("t1_so", steep_octant, 1);
        chk("t1_oct", octant, 0);
        chk("t1_major", major_len, 10);
        chk("t1_err", $signed(err_init), -4);
        chk("t1_tag", tag_out, 5);
        align();

        send_lat(5, 5, 2, 20, 0);
        chk("t2_dx", $signed(dx), -3);
        chk("t2_so", steep_octant, 3);
        chk("t2_oct", octant, 5);
        chk("t2_major", major_len, 15);
        chk("t2_err", $signed(err_init), -9);
        chk("t2_swapped", swapped, 0);
        chk("t2_start_x", start_x, 5);
        align();

        send_lat(20, 8, 4, 8, 1);
`ifdef LINE_SETUP_SWAP_EN
        chk("t3_dx", $signed(dx), 16);
        chk("t3_x_step", x_step, 0);
        chk("t3_swapped", swapped, 1);
        chk("t3_start_x", start_x, 4);
        chk("t3_end_x", end_x, 20);
`else
        chk("t3_dx", $signed(dx), -16);
        chk("t3_x_step", x_step, 1);
        chk("t3_swapped", swapped, 0);
`endif
        align();

        send_one(7, 7, 7, 7, 2);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                chk("t4_degen", degenerate, 1);
                chk("t4_major", major_len, 0);
                chk("t4_err", $signed(err_init), 0);
            end
        end
        chk("t4_pulses", cnt, 1);
        align();

        send_lat(0, 0, 1023, 0, 3);
        chk("t5_abs_dx", abs_dx, 1023);
        chk("t5_err", $signed(err_init), -1023);
        align();
        send_lat(1023, 1023, 0, 0, 4);
        chk("t6_abs_dx", abs_dx, 1023);
        chk("t6_abs_dy", abs_dy, 1023);
        chk("t6_steep", steep, 0);
`ifdef LINE_SETUP_SWAP_EN
        chk("t6_dx", $signed(dx), 1023);
`else
        chk("t6_dx", $signed(dx), -1023);
        chk("t6_dy", $signed(dy), -1023);
`endif
        align();

        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send_one(rc(), rc(), rc(), rc(), int'($urandom_range(0, 15)));
            end
            begin
                int n = 0;
                while (acc_cnt < base + 2 && n < 100) begin
                    @(posedge clk);
                    n++;
                end
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) send_one(rc(), rc(), rc(), rc(), i);
        out_ready = 1'b0;
        rst = 1'b1;
        align();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        align();
        out_ready = 1'b1;
        repeat (6) align();

        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) align();
                    send_one(rc(), rc(), rc(), rc(), int'($urandom_range(0, 15)));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("sb_final", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
